// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the NPC instruction sequencer: state encoding,
// halt reason codes and datapath select constants.
package inst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_IWAIT = 3'd2,
    ST_EXEC  = 3'd3,
    ST_MREQ  = 3'd4,
    ST_MWAIT = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_BUS     = 2'd3;

  localparam logic [1:0] PC_FROM_PLUS4 = 2'd0;
  localparam logic [1:0] PC_FROM_ALU   = 2'd1;

  localparam logic [1:0] WRITEBACK_ALU = 2'd0;
  localparam logic [1:0] WRITEBACK_MEM = 2'd1;
  localparam logic [1:0] WRITEBACK_PC4 = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic is_fetching(input state_t s);
    return (s == ST_FETCH) || (s == ST_IWAIT);
  endfunction

endpackage

// File: rtl/inst_sequencer_perf_counters.sv
// 64-bit free-running cycle and retired-instruction counters with
// independent enables; both wrap modulo 2^64.
module perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        cycle_en,
  input  logic        instret_en,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  logic [1:0] en;
  assign en = {instret_en, cycle_en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [63:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= 64'd0;
      end else if (en[gi]) begin
        cnt_reg <= cnt_reg + 64'd1;
      end
    end
  end

  assign mcycle   = g_cnt[0].cnt_reg;
  assign minstret = g_cnt[1].cnt_reg;

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle sequencer: owns PC and IR, handshakes with fetch and load/store
// ports, commits each instruction once and halts on ebreak/illegal/bus error.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic [31:0] inst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_data,
  input  logic        ifu_resp_err,
  input  logic        dec_reg_wen,
  input  logic        dec_is_mem,
  input  logic        dec_is_ebreak,
  input  logic        dec_illegal,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        rf_we,
  output logic        retire,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, inst_reg;
  logic [TW-1:0] tmo_reg;
  logic          halt_reg;
  logic [1:0]    code_reg, code_next;
  logic          commit, retire_c, tmo_hit;

  assign tmo_hit = (tmo_reg == TMO_LAST);

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    commit     = 1'b0;
    retire_c   = 1'b0;
    case (state_reg)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: begin
        if (tmo_hit) begin
          state_next = ST_HALT;
          code_next  = HALT_BUS;
        end else if (ifu_req_ready) begin
          state_next = ST_IWAIT;
        end
      end
      ST_IWAIT: begin
        // An accepted response wins over a timeout in the same cycle.
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            state_next = ST_HALT;
            code_next  = HALT_BUS;
          end else begin
            state_next = ST_EXEC;
          end
        end else if (tmo_hit) begin
          state_next = ST_HALT;
          code_next  = HALT_BUS;
        end
      end
      ST_EXEC: begin
        if (dec_illegal) begin
          state_next = ST_HALT;
          code_next  = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          retire_c   = 1'b1;
          state_next = ST_HALT;
          code_next  = HALT_EBREAK;
        end else if (dec_is_mem) begin
          state_next = ST_MREQ;
        end else begin
          commit     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_MREQ:  if (lsu_req_ready) state_next = ST_MWAIT;
      ST_MWAIT: begin
        if (lsu_resp_valid) begin
          commit     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
    if (commit) retire_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= NOP;
      tmo_reg   <= '0;
      halt_reg  <= 1'b0;
      code_reg  <= HALT_NONE;
    end else begin
      state_reg <= state_next;
      if (commit) pc_reg <= next_pc;
      if (state_reg == ST_IWAIT && ifu_resp_valid && !ifu_resp_err) inst_reg <= ifu_resp_data;
      if (state_next == ST_FETCH && state_reg != ST_FETCH) begin
        tmo_reg <= '0;
      end else if (is_fetching(state_reg)) begin
        tmo_reg <= tmo_reg + TW'(1);
      end
      if (state_next == ST_HALT && state_reg != ST_HALT) begin
        halt_reg <= 1'b1;
        code_reg <= code_next;
      end
    end
  end

  perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .cycle_en   (state_reg != ST_HALT),
    .instret_en (retire_c),
    .mcycle     (mcycle),
    .minstret   (minstret)
  );

  assign pc            = pc_reg;
  assign inst          = inst_reg;
  assign ifu_req_valid = (state_reg == ST_FETCH);
  assign lsu_req_valid = (state_reg == ST_MREQ);
  assign rf_we         = commit & dec_reg_wen;
  assign retire        = retire_c;
  assign halt          = halt_reg;
  assign halt_code     = code_reg;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed-plus-random bench for inst_sequencer; expected PC, counters and
// halt codes come from per-instruction cycle arithmetic.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 8;

  logic        clk, rst;
  logic [31:0] pc, next_pc, inst, ifu_resp_data;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic        dec_reg_wen, dec_is_mem, dec_is_ebreak, dec_illegal;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic        rf_we, retire, halt;
  logic [1:0]  halt_code;
  logic [63:0] mcycle, minstret;

  inst_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .inst(inst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .ifu_resp_err(ifu_resp_err), .dec_reg_wen(dec_reg_wen),
    .dec_is_mem(dec_is_mem), .dec_is_ebreak(dec_is_ebreak),
    .dec_illegal(dec_illegal), .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
    .rf_we(rf_we), .retire(retire), .halt(halt), .halt_code(halt_code),
    .mcycle(mcycle), .minstret(minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_pc, cur_inst;
  logic [63:0] exp_mcycle, exp_minstret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    next_pc = 32'h0; ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_data = 32'h0;
    ifu_resp_err = 0; dec_reg_wen = 0; dec_is_mem = 0; dec_is_ebreak = 0;
    dec_illegal = 0; lsu_req_ready = 0; lsu_resp_valid = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_code"}, halt_code, 0);
    chk({tag, "_mcycle"}, mcycle, 0);
    chk({tag, "_minstret"}, minstret, 0);
    chk({tag, "_valids"}, {ifu_req_valid, lsu_req_valid, retire, rf_we}, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_values("reset");
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_req", ifu_req_valid, 0);
    chk("idle_mcycle", mcycle, 0);
    exp_pc = RST_PC; exp_mcycle = 64'd1; exp_minstret = 64'd0; cur_inst = NOP;
    tick();
  endtask

  // Runs one instruction starting from the first FETCH cycle.
  task automatic do_insn(input logic [31:0] word, input bit mem, input bit ebrk,
                         input bit ill, input bit wen, input bit err,
                         input logic [31:0] nxt, input int rd, input int rsp,
                         input int lrd, input int lrs, input bit rst_mwait);
    logic [31:0] junk;
    dec_is_mem = mem; dec_is_ebreak = ebrk; dec_illegal = ill;
    dec_reg_wen = wen; next_pc = nxt;
    for (int i = 0; i <= rd; i++) begin
      ifu_req_ready = (i == rd);
      #1;
      chk("fetch_valid", ifu_req_valid, 1);
      chk("fetch_pc", pc, exp_pc);
      if (i == 0) begin
        chk("fetch_mcycle", mcycle, exp_mcycle);
        chk("fetch_minstret", minstret, exp_minstret);
      end
      tick();
    end
    ifu_req_ready = 0;
    for (int i = 0; i <= rsp; i++) begin
      junk = $urandom;
      ifu_resp_valid = (i == rsp);
      ifu_resp_data  = (i == rsp) ? word : junk;
      ifu_resp_err   = (i == rsp) && err;
      #1;
      chk("iwait_req", ifu_req_valid, 0);
      chk("iwait_retire", retire, 0);
      tick();
    end
    ifu_resp_valid = 0; ifu_resp_err = 0;
    exp_mcycle += 64'(rd + rsp + 2);
    if (err) begin
      #1;
      chk("err_halt", {halt, halt_code}, {1'b1, HALT_BUS});
      chk("err_inst", inst, cur_inst);
      chk("err_pc", pc, exp_pc);
      chk("err_mcycle", mcycle, exp_mcycle);
      return;
    end
    #1;
    chk("exec_inst", inst, word);
    chk("exec_retire", retire, !ill && (ebrk || !mem));
    chk("exec_rf_we", rf_we, !ill && !ebrk && !mem && wen);
    chk("exec_lsu", lsu_req_valid, 0);
    tick();
    exp_mcycle += 64'd1;
    cur_inst = word;
    if (ill || ebrk) begin
      if (ebrk) exp_minstret += 64'd1;
      #1;
      chk("halt_flag", halt, 1);
      chk("halt_code", halt_code, ill ? HALT_ILLEGAL : HALT_EBREAK);
      chk("halt_pc", pc, exp_pc);
      chk("halt_minstret", minstret, exp_minstret);
      chk("halt_mcycle", mcycle, exp_mcycle);
      return;
    end
    if (mem) begin
      for (int i = 0; i <= lrd; i++) begin
        lsu_req_ready = (i == lrd);
        #1;
        chk("mreq_valid", lsu_req_valid, 1);
        chk("mreq_retire", {retire, rf_we}, 0);
        chk("mreq_pc", pc, exp_pc);
        tick();
      end
      lsu_req_ready = 0;
      for (int i = 0; i <= lrs; i++) begin
        lsu_resp_valid = (i == lrs);
        #1;
        chk("mwait_retire", retire, (i == lrs));
        chk("mwait_rf_we", rf_we, (i == lrs) && wen);
        chk("mwait_lsu", lsu_req_valid, 0);
        chk("mwait_pc", pc, exp_pc);
        chk("mwait_inst", inst, word);
        if (rst_mwait) begin
          lsu_resp_valid = 0;
          rst = 1'b1;
          #1;
          chk_reset_values("async_rst");
          return;
        end
        tick();
      end
      lsu_resp_valid = 0;
      exp_mcycle += 64'(lrd + lrs + 2);
    end
    exp_pc = nxt;
    exp_minstret += 64'd1;
  endtask

  task automatic freeze(input int n);
    logic [31:0] junk;
    for (int i = 0; i < n; i++) begin
      junk = $urandom;
      ifu_req_ready = 1; ifu_resp_valid = 1; ifu_resp_data = junk;
      lsu_req_ready = 1; lsu_resp_valid = 1;
      #1;
      chk("frozen_outputs", {ifu_req_valid, lsu_req_valid, retire, rf_we}, 0);
      chk("frozen_mcycle", mcycle, exp_mcycle);
      chk("frozen_pc", pc, exp_pc);
      chk("frozen_halt", halt, 1);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, w;
    do_reset();
    do_insn(32'h0050_0093, 0, 0, 0, 1, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
    do_insn(32'h0000_0013, 0, 0, 0, 0, 0, 32'h8000_0008, 5, 0, 0, 0, 0);
    do_insn(32'h0000_2083, 1, 0, 0, 1, 0, 32'h8000_000c, 0, 1, 2, 3, 0);
    do_insn(32'h0010_0113, 0, 0, 0, 1, 0, 32'h8000_0010, 3, 3, 0, 0, 0);
    for (int n = 0; n < 30; n++) begin
      r = $urandom;
      w = $urandom;
      do_insn(w, r[0], 0, 0, r[1], 0, {r[31:10], 8'h00, 2'b00},
              int'(r[3:2]), int'(r[5:4]), int'(r[7:6]), int'(r[9:8]), 0);
    end
    do_insn(32'h0010_0073, 0, 1, 0, 1, 0, 32'h1234_5678, 1, 1, 0, 0, 0);
    freeze(4);

    do_reset();
    do_insn(32'hffff_ffff, 0, 0, 1, 1, 0, 32'h8000_0004, 0, 1, 0, 0, 0);
    freeze(2);

    do_reset();
    do_insn(32'h0000_0013, 0, 0, 0, 0, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
    do_insn(32'hdead_beef, 0, 0, 0, 1, 1, 32'h8000_0008, 1, 2, 0, 0, 0);
    freeze(2);

    do_reset();
    for (int k = 0; k < TMO; k++) begin
      ifu_req_ready = (k == 0);
      #1;
      chk("tmo_running", halt, 0);
      tick();
    end
    ifu_req_ready = 0;
    exp_mcycle += 64'(TMO);
    #1;
    chk("tmo_halt", {halt, halt_code}, {1'b1, HALT_BUS});
    chk("tmo_mcycle", mcycle, exp_mcycle);

    do_reset();
    do_insn(32'h0000_2083, 0, 0, 0, 1, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
    do_insn(32'h0040_2103, 1, 0, 0, 1, 0, 32'h8000_0100, 0, 0, 1, 3, 1);
    do_reset();
    do_insn(32'h0000_0013, 0, 0, 0, 1, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
    #1;
    chk("after_rst_pc", pc, 32'h8000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
